// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer: latches the two memory-lane requests of one instruction
// and issues them one after the other (lane 1, then lane 2) on the RAM or system
// bus. Each access waits for the bus ack. A lane that waits too long is aborted.
// busy holds the pipeline until both lanes have finished.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results and err hold from the last operation
// L1    | lane 1 access on its selected bus, waiting for ack or timeout
// L2    | lane 2 access on its selected bus, waiting for ack or timeout
// DONE  | one-cycle done pulse; busy still high
module mem_port_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        l1_en,
  input  logic        l2_en,
  input  logic        l1_we,
  input  logic        l2_we,
  input  logic        l1_sys,
  input  logic        l2_sys,
  input  logic [31:0] l1_addr,
  input  logic [31:0] l2_addr,
  input  logic [31:0] l1_wdata,
  input  logic [31:0] l2_wdata,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] sys_rdata,
  input  logic        ram_ack,
  input  logic        sys_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] m1_data,
  output logic [31:0] m2_data,
  output logic [31:0] ram_addr,
  output logic [31:0] sys_addr,
  output logic [31:0] ram_wdata,
  output logic [31:0] sys_wdata,
  output logic        ram_r,
  output logic        ram_w,
  output logic        sys_r,
  output logic        sys_w
);

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic        sys;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lane_t;

  typedef struct packed {
    logic        ram_r;
    logic        ram_w;
    logic        sys_r;
    logic        sys_w;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
  } bus_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  lane_t       lane1;
  lane_t       lane2;
  logic        lane2_en;
  bus_t        bus_q;
  logic [7:0]  wait_cnt;

  lane_t       in1;
  lane_t       in2;
  lane_t       cur;
  logic        cur_ack;
  logic [31:0] cur_rdata;
  logic [31:0] cur_result;
  logic        timed_out;

  // Bus drive for one lane: only the selected bus is active, the other stays at 0.
  function automatic bus_t lane_bus(input lane_t ln);
    bus_t b;
    b = '0;
    if (ln.sys) begin
      b.sys_r     = !ln.we;
      b.sys_w     = ln.we;
      b.sys_addr  = ln.addr;
      b.sys_wdata = ln.wdata;
    end else begin
      b.ram_r     = !ln.we;
      b.ram_w     = ln.we;
      b.ram_addr  = ln.addr;
      b.ram_wdata = ln.wdata;
    end
    return b;
  endfunction

  assign in1 = '{we: l1_we, sys: l1_sys, addr: l1_addr, wdata: l1_wdata};
  assign in2 = '{we: l2_we, sys: l2_sys, addr: l2_addr, wdata: l2_wdata};

  // Ack and read data are taken only from the bus the active lane selected.
  assign cur        = (state == L2) ? lane2 : lane1;
  assign cur_ack    = cur.sys ? sys_ack : ram_ack;
  assign cur_rdata  = cur.sys ? sys_rdata : ram_rdata;
  assign cur_result = cur.we ? cur.wdata : cur_rdata;
  assign timed_out  = (wait_cnt == TIMEOUT_CNT);

  // Sequencer FSM. Bus strobes and results are registered and change only with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lane1    <= '0;
      lane2    <= '0;
      lane2_en <= 1'b0;
      bus_q    <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      m1_data  <= '0;
      m2_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lane1    <= in1;
            lane2    <= in2;
            lane2_en <= l2_en;
            m1_data  <= '0;
            m2_data  <= '0;
            err      <= 1'b0;
            wait_cnt <= '0;
            busy     <= 1'b1;
            if (l1_en) begin
              state <= L1;
              bus_q <= lane_bus(in1);
            end else if (l2_en) begin
              state <= L2;
              bus_q <= lane_bus(in2);
            end else begin
              state <= DONE;
              bus_q <= '0;
              done  <= 1'b1;
            end
          end
        end

        L1, L2: begin
          if (cur_ack || timed_out) begin
            // An ack in the timeout cycle counts as a normal completion.
            if (!cur_ack) begin
              err <= 1'b1;
            end
            if (state == L1) begin
              m1_data <= cur_ack ? cur_result : '0;
            end else begin
              m2_data <= cur_ack ? cur_result : '0;
            end
            wait_cnt <= '0;
            if (state == L1 && lane2_en) begin
              state <= L2;
              bus_q <= lane_bus(lane2);
            end else begin
              state <= DONE;
              bus_q <= '0;
              done  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          bus_q <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_r     = bus_q.ram_r;
  assign ram_w     = bus_q.ram_w;
  assign sys_r     = bus_q.sys_r;
  assign sys_w     = bus_q.sys_w;
  assign ram_addr  = bus_q.ram_addr;
  assign ram_wdata = bus_q.ram_wdata;
  assign sys_addr  = bus_q.sys_addr;
  assign sys_wdata = bus_q.sys_wdata;

endmodule
